// File: rtl/rf_pkg.sv
// Package for the Tomasulo register-file front end.
// Holds default widths for the register file and typedefs at those
// default widths for consumers that do not re-parameterise.
package rf_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;
endpackage

// File: rtl/rr_multi_grant.sv
// Round-robin multi-grant arbiter (purely combinational).
// Scans req starting at ptr, wrapping modulo N, and grants up to K
// requesters. next_ptr points one past the last granted index, or
// equals ptr when nothing is granted.
// Ports:
//   req      in  N   request vector
//   ptr      in  PW  scan start index (must be < N)
//   grant    out N   granted subset of req (at most K bits set)
//   next_ptr out PW  pointer value for the next cycle
module rr_multi_grant #(
  parameter int N  = 4,
  parameter int K  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);
  always_comb begin
    int idx;
    int cnt;
    grant    = '0;
    next_ptr = ptr;
    cnt      = 0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx] && cnt < K) begin
        grant[idx] = 1'b1;
        cnt        = cnt + 1;
        next_ptr   = PW'((idx + 1) % N);
      end
    end
  end
endmodule

// File: rtl/rf_multiport_arbiter.sv
// Register-file front end: NREGS x XLEN architectural storage, NUM_CH
// operand-read channels served over NUM_RD_PORTS read ports via
// round-robin multi-grant arbitration, 1-cycle registered responses,
// and one non-stalling write per cycle.
// Optional macro RF_BYPASS_EN: when defined, a read granted in the same
// cycle as a write to the same (nonzero) address returns the new data;
// otherwise it returns the pre-write value.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_addr    per-channel read request and register index
//   req_ready             per-channel grant (combinational)
//   rsp_valid/rsp_data    registered read response, data held when idle
//   wr_valid/wr_addr/wr_data  write port
module rf_multiport_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter int XLEN         = DEF_XLEN,
  parameter int NREGS        = DEF_NREGS,
  parameter int AW           = $clog2(NREGS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                req_valid,
  input  logic [NUM_CH-1:0][AW-1:0]        req_addr,
  output logic [NUM_CH-1:0]                req_ready,
  output logic [NUM_CH-1:0]                rsp_valid,
  output logic [NUM_CH-1:0][XLEN-1:0]      rsp_data,
  input  logic                             wr_valid,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [XLEN-1:0]                  wr_data
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [XLEN-1:0]   mem [NREGS];
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     next_ptr;
  logic [NUM_CH-1:0] grant;
  logic              wr_ok;

  // Requests are masked while in reset so no grant can appear.
  rr_multi_grant #(.N(NUM_CH), .K(NUM_RD_PORTS), .PW(PW)) u_arb (
    .req      (req_valid & {NUM_CH{rst_n}}),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign req_ready = grant;
  assign wr_ok     = wr_valid && (wr_addr != '0) && (int'(wr_addr) < NREGS);

  // x0 and out-of-range indices read as zero.
  function automatic logic [XLEN-1:0] rd_word(input logic [AW-1:0] a);
    if (a == '0 || int'(a) >= NREGS) return '0;
`ifdef RF_BYPASS_EN
    if (wr_valid && wr_addr == a) return wr_data;
`endif
    return mem[a];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // rr_ptr only moves when something was granted (next_ptr == rr_ptr otherwise).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rr_ptr <= next_ptr;
      for (int c = 0; c < NUM_CH; c++) begin
        rsp_valid[c] <= grant[c];
        if (grant[c]) rsp_data[c] <= rd_word(req_addr[c]);
      end
    end
  end
endmodule

// File: tb/tb_rf_multiport_arbiter.sv
// Self-checking bench for rf_multiport_arbiter: directed scenarios plus a
// randomized run, all checked against a behavioural model of the register
// file and the round-robin grant rule. Expectations follow RF_BYPASS_EN.
module tb_rf_multiport_arbiter;
  localparam int NUM_CH = 4;
  localparam int K      = 2;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH-1:0][AW-1:0]   req_addr;
  logic [NUM_CH-1:0]           req_ready;
  logic [NUM_CH-1:0]           rsp_valid;
  logic [NUM_CH-1:0][XLEN-1:0] rsp_data;
  logic                        wr_valid;
  logic [AW-1:0]               wr_addr;
  logic [XLEN-1:0]             wr_data;

  rf_multiport_arbiter #(.NUM_CH(NUM_CH), .NUM_RD_PORTS(K), .XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [XLEN-1:0]             m_rf [NREGS];
  int                          m_ptr;
  int                          m_next_ptr;
  logic [NUM_CH-1:0]           exp_grant;
  logic [NUM_CH-1:0]           exp_rsp_valid;
  logic [NUM_CH-1:0][XLEN-1:0] exp_rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    m_ptr = 0; m_next_ptr = 0;
    exp_grant = '0; exp_rsp_valid = '0; exp_rsp_data = '0;
  endtask

  // Requesting channels listed in scan order from the pointer; the first K win.
  task automatic model_grant();
    int q[$];
    exp_grant  = '0;
    m_next_ptr = m_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      c = (m_ptr + i) % NUM_CH;
      if (req_valid[c]) q.push_back(c);
    end
    for (int i = 0; i < q.size() && i < K; i++) begin
      exp_grant[q[i]] = 1'b1;
      m_next_ptr = (q[i] + 1) % NUM_CH;
    end
  endtask

  // Apply the clock edge to the model: responses, then the write, then pointer.
  task automatic model_commit();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_rsp_valid[c] = exp_grant[c];
      if (exp_grant[c]) begin
        int a;
        a = int'(req_addr[c]);
        if (a == 0) exp_rsp_data[c] = '0;
        else if (BYP && wr_valid && int'(wr_addr) == a) exp_rsp_data[c] = wr_data;
        else exp_rsp_data[c] = m_rf[a];
      end
    end
    if (wr_valid && wr_addr != 0) m_rf[wr_addr] = wr_data;
    m_ptr = m_next_ptr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    #2;
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready_edge got=%b exp=0", req_ready); end
    @(negedge clk); rst_n = 1'b1; req_valid = '0;
    model_reset();
    @(posedge clk); #1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL idle_ready cyc=%0d got=%b exp=0", t, req_ready); end
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== '0 || rsp_data !== '0) begin
        n_err++; $display("FAIL idle_rsp cyc=%0d got v=%b d=%h exp 0", t, rsp_valid, rsp_data);
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    // T: write reg5
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    @(negedge clk); model_grant(); model_commit();
    @(posedge clk); #1;
    // T+1: ch0 reads reg5
    wr_valid = 1'b0; req_valid = 4'b0001; req_addr[0] = 5'd5;
    @(negedge clk); model_grant();
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_rd_ready got=%b exp=0001", req_ready); end
    model_commit();
    @(posedge clk); #1;
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL wr_rd_valid got=%b exp=0001", rsp_valid); end
    n_cmp++; if (rsp_data[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_data got=%h exp=deadbeef", rsp_data[0]); end
    // pulse falls and data holds
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== '0 || rsp_data[0] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_rd_hold got v=%b d=%h exp v=0 d=deadbeef", rsp_valid, rsp_data[0]);
    end
  endtask

  task automatic test_fairness();
    logic [NUM_CH-1:0] pat [4];
    pat[0] = 4'b0011; pat[1] = 4'b1100; pat[2] = 4'b0011; pat[3] = 4'b1100;
    do_reset();
    req_valid = '1;
    for (int c = 0; c < NUM_CH; c++) req_addr[c] = AW'(c);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); model_grant();
      n_cmp++; if (req_ready !== pat[t]) begin n_err++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", t, req_ready, pat[t]); end
      model_commit();
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== pat[t]) begin n_err++; $display("FAIL rr_rsp cyc=%0d got=%b exp=%b", t, rsp_valid, pat[t]); end
    end
    req_valid = '0;
  endtask

  task automatic test_x0();
    do_reset();
    wr_valid = 1'b1; wr_addr = '0; wr_data = 32'h12345678;
    @(negedge clk); model_grant(); model_commit();
    @(posedge clk); #1;
    wr_valid = 1'b0; req_valid = 4'b0100; req_addr[2] = '0;
    @(negedge clk); model_grant(); model_commit();
    @(posedge clk); #1;
    req_valid = '0;
    n_cmp++; if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== '0) begin
      n_err++; $display("FAIL x0_read got v=%b d=%h exp v=1 d=0", rsp_valid[2], rsp_data[2]);
    end
  endtask

  task automatic test_same_cycle_rw();
    logic [XLEN-1:0] exp;
    exp = BYP ? 32'h2 : 32'h1;
    do_reset();
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    @(negedge clk); model_grant(); model_commit();
    @(posedge clk); #1;
    wr_data = 32'h2; req_valid = 4'b0010; req_addr[1] = 5'd7;
    @(negedge clk); model_grant(); model_commit();
    @(posedge clk); #1;
    wr_valid = 1'b0;
    n_cmp++; if (rsp_data[1] !== exp) begin n_err++; $display("FAIL rw_collide got=%h exp=%h", rsp_data[1], exp); end
    @(negedge clk); model_grant(); model_commit();
    @(posedge clk); #1;
    req_valid = '0;
    n_cmp++; if (rsp_data[1] !== 32'h2) begin n_err++; $display("FAIL rw_after got=%h exp=2", rsp_data[1]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b0010; req_addr[1] = 5'd3;
    @(negedge clk); model_grant(); model_commit();
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL arst_pre got=%b exp=0010", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL arst_drop got=%b exp=0", rsp_valid); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL arst_ready got=%b exp=0", req_ready); end
    req_valid = 4'b1110;
    for (int c = 0; c < NUM_CH; c++) req_addr[c] = AW'(c);
    @(negedge clk); rst_n = 1'b1; model_reset();
    #1; model_grant();
    n_cmp++; if (req_ready !== 4'b0110) begin n_err++; $display("FAIL arst_restart got=%b exp=0110", req_ready); end
    model_commit();
    @(posedge clk); #1;
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 4'b0110) begin n_err++; $display("FAIL arst_rsp got=%b exp=0110", rsp_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      // hold ungranted requests; otherwise redraw
      for (int c = 0; c < NUM_CH; c++) begin
        if (!(req_valid[c] && !exp_grant[c])) begin
          req_valid[c] = ($urandom_range(0, 9) < 6);
          req_addr[c]  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS-1));
        end
      end
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      @(negedge clk); model_grant();
      n_cmp++; if (req_ready !== exp_grant) begin n_err++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", t, req_ready, exp_grant); end
      model_commit();
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", t, rsp_valid, exp_rsp_valid); end
      n_cmp++; if (rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", t, rsp_data, exp_rsp_data); end
    end
    req_valid = '0; wr_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_fairness();
    test_x0();
    test_same_cycle_rw();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_multiport_arbiter.md
Name: rf_multiport_arbiter

Overview:
- Parametrised successor to the team's single-grant register-file front end for the Tomasulo core.
- Owns the architectural register storage (NREGS x XLEN).
- Serves NUM_CH operand-read channels (reservation-station operand slots) over NUM_RD_PORTS physical read ports, using round-robin multi-grant arbitration, with a 1-cycle registered response.
- Accepts one CDB/commit write per cycle; writes never stall.

Parameters:
- NUM_CH, 4, number of independent read-request channels
- NUM_RD_PORTS, 2, max reads granted per cycle (1..NUM_CH)
- XLEN, 32, data width
- NREGS, 32, register count; AW = $clog2(NREGS)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_CH  per-channel read request
- req_addr  in  NUM_CH x AW  per-channel register index
- req_ready  out  NUM_CH  grant; request accepted this cycle when req_valid & req_ready
- rsp_valid  out  NUM_CH  registered: read data valid
- rsp_data  out  NUM_CH x XLEN  registered read data
- wr_valid  in  1  write enable
- wr_addr  in  AW  write index
- wr_data  in  XLEN  write data

Behaviour:
- Reset (async, rst_n=0):
  - All registers cleared to 0.
  - rsp_valid=0, rsp_data=0, rr_ptr=0.
  - req_ready=0 while rst_n=0.
- Arbitration (combinational, same cycle):
  - Scan channels starting at rr_ptr, wrapping modulo NUM_CH.
  - Grant the first min(NUM_RD_PORTS, #requesting) requesting channels.
  - req_ready is asserted only for granted channels. It may depend on req_valid but never on rsp_*.
- Pointer update:
  - If at least one grant occurs, rr_ptr <= (index of last granted channel + 1) mod NUM_CH.
  - Otherwise rr_ptr holds.
- Handshake:
  - A requester holds req_valid and req_addr stable until it sees req_ready.
  - An ungranted request has no side effect.
- Latency:
  - A grant in cycle T gives rsp_valid[ch]=1 with rsp_data[ch] in cycle T+1.
  - rsp_valid is a one-cycle pulse, then falls unless granted again in T+1.
  - Back-to-back grants give back-to-back responses.
- rsp_data holds its last value when rsp_valid=0.
- Register x0: reads always return 0; writes to address 0 are ignored.
- Write:
  - When wr_valid=1 and wr_addr!=0, reg[wr_addr] <= wr_data at the edge.
  - A write in cycle T is visible to all reads granted in T+1 or later.
- Simultaneous read and write to the same address in cycle T: see RF_BYPASS_EN.
- Multiple channels reading the same address in one cycle: all granted channels receive identical data.
- Out-of-range address (req_addr >= NREGS, when NREGS is not a power of 2): returns 0; write ignored.
- Reset asserted mid-transaction: in-flight responses are dropped and rsp_valid=0 immediately. After deassertion, arbitration restarts at channel 0.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read granted in cycle T with req_addr==wr_addr, wr_valid=1 and addr!=0 returns wr_data in T+1 (write-first forwarding).
- Undefined: the read returns the pre-write register value (read-first). Bench expectations switch on the same macro.

Decomposition:
- Package rf_pkg holds:
  - Constants XLEN and NREGS defaults.
  - Typedefs reg_addr_t (logic [AW-1:0]) and xlen_t (logic [XLEN-1:0]).
- Sub-module rr_multi_grant (parametrised N, K):
  - Inputs: req[N], ptr.
  - Outputs: grant[N], next_ptr.
  - Purely combinational. It is the natural unit for reuse by the CDB arbiter.

Test Plan:
- Reset then idle: after rst_n rises, all req_valid=0 for 5 cycles -> rsp_valid=0, rsp_data=0, no req_ready.
- Write/read: write reg5=0xDEADBEEF at T, ch0 requests addr5 at T+1 -> req_ready[0]=1 at T+1, rsp_valid[0]=1, rsp_data[0]=0xDEADBEEF at T+2.
- Round-robin fairness: all 4 channels request continuously (NUM_RD_PORTS=2) -> grants {0,1},{2,3},{0,1} on successive cycles; each channel receives one response every 2 cycles.
- x0 protection: write addr0=0x12345678, then ch2 reads addr0 -> rsp_data[2]=0.
- Same-cycle read/write to addr7: old=0x1, writing 0x2 -> rsp_data=0x2 with RF_BYPASS_EN, 0x1 without.
- Async reset mid-run: rst_n falls while ch1 is granted (between edges) -> rsp_valid drops to 0 immediately. After release, the first grant goes to the lowest requesting channel from 0.
